// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default sizing for the instruction fetch unit.
package fetch_pkg;
  localparam int DEFAULT_INSTRUCTION_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: control, instruction-memory and instruction-register signals of the fetch unit.
interface instruction_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic fetch_start;
  logic pc_load;
  logic [ADDR_WIDTH-1:0] pc_load_value;
  logic mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic mem_rd_valid;
  logic [INSTRUCTION_WIDTH-1:0] mem_rd_data;
  logic [INSTRUCTION_WIDTH-1:0] ir_data;
  logic ir_wr;
  logic [ADDR_WIDTH-1:0] pc;
  logic busy;
  logic fetch_done;
  logic fetch_error;
  modport master (
    input fetch_start, pc_load, pc_load_value, mem_rd_valid, mem_rd_data,
    output mem_rd_req, mem_rd_addr, ir_data, ir_wr, pc, busy, fetch_done, fetch_error
  );
  modport slave (
    output fetch_start, pc_load, pc_load_value, mem_rd_valid, mem_rd_data,
    input mem_rd_req, mem_rd_addr, ir_data, ir_wr, pc, busy, fetch_done, fetch_error
  );
endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// program_counter: PC register with async reset, priority load and wrapping increment.
module program_counter #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic ir_reset,
  input  logic load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic inc,
  output logic [ADDR_WIDTH-1:0] pc
);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  always_comb pc_d = load ? load_value : inc ? pc_q + ADDR_WIDTH'(1) : pc_q;
  always_ff @(posedge clock or posedge ir_reset)
    if (ir_reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches one instruction word per request into the IR and owns the PC.
// Define FETCH_TIMEOUT_EN to abort a WAIT that sees no read data within TIMEOUT_CYCLES.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic clock,
  input logic ir_reset,
  instruction_fetch_unit_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_data_q, ir_data_d;
  logic mem_rd_req_q, mem_rd_req_d;
  logic ir_wr_q, ir_wr_d;
  logic fetch_error_q, fetch_error_d;
  logic redirect_q, redirect_d;
  logic expire;
  logic [ADDR_WIDTH-1:0] pc;
`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  always_comb timer_d = state_q == REQ ? TW'(TIMEOUT_CYCLES) : state_q == WAIT ? timer_q - TW'(1) : timer_q;
  always_ff @(posedge clock or posedge ir_reset)
    if (ir_reset) timer_q <= '0;
    else timer_q <= timer_d;
  assign expire = timer_q == TW'(1);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ir_data_d = ir_data_q;
    fetch_error_d = 1'b0;
    case (state_q)
      IDLE: state_d = bus.fetch_start ? REQ : IDLE;
      REQ: state_d = WAIT;
      WAIT:
        if (bus.mem_rd_valid) begin
          state_d = WRITE;
          ir_data_d = bus.mem_rd_data;
        end else if (expire) begin
          state_d = IDLE;
          fetch_error_d = 1'b1;
        end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_rd_req_d = state_d == REQ;
    ir_wr_d = state_d == WRITE;
    // a branch taken while a fetch is in flight replaces that fetch's PC increment
    redirect_d = (state_q == REQ || state_q == WAIT) && (redirect_q || bus.pc_load);
  end
  always_ff @(posedge clock or posedge ir_reset)
    if (ir_reset) begin
      state_q <= IDLE;
      ir_data_q <= '0;
      mem_rd_req_q <= 1'b0;
      ir_wr_q <= 1'b0;
      fetch_error_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_data_q <= ir_data_d;
      mem_rd_req_q <= mem_rd_req_d;
      ir_wr_q <= ir_wr_d;
      fetch_error_q <= fetch_error_d;
      redirect_q <= redirect_d;
    end
  program_counter #(.ADDR_WIDTH(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clock(clock),
    .ir_reset(ir_reset),
    .load(bus.pc_load),
    .load_value(bus.pc_load_value),
    .inc(state_q == WRITE && !redirect_q),
    .pc(pc)
  );
  assign bus.mem_rd_req = mem_rd_req_q;
  assign bus.mem_rd_addr = pc;
  assign bus.ir_data = ir_data_q;
  assign bus.ir_wr = ir_wr_q;
  assign bus.fetch_done = ir_wr_q;
  assign bus.fetch_error = fetch_error_q;
  assign bus.pc = pc;
  assign bus.busy = state_q != IDLE;
endmodule
